// File: rtl/protocol_pkg.sv
// Shared protocol types for the I2S receive path.
package protocol_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } i2s_rx_state_t;

endpackage

// File: rtl/constants.svh
// Project-wide numeric defaults shared by the audio datapath blocks.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define SAMPLE_WIDTH 24

`endif

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a third stage for edge detection.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [2:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            // NOTE: non-blocking assignment keeps each stage one clk behind the previous one.
            pipe <= {pipe[1:0], din};
        end
    end

    assign sync = pipe[1];
    assign rise = pipe[1] & ~pipe[2];
    assign fall = ~pipe[1] & pipe[2];

endmodule

// File: rtl/i2s_receiver.sv
// I2S/Philips serial receiver: recovers left/right words from sclk/lrclk/sd and
// publishes a pair once framing is stable.
`include "constants.svh"

module i2s_receiver
    import protocol_pkg::*;
#(
    parameter int WIDTH = `SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sd,
    output logic [WIDTH-1:0] left_data,
    output logic [WIDTH-1:0] right_data,
    output logic             sample_valid,
    output logic             locked,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 2);

    logic             sclk_rise, lr_s, sd_s;
    logic             unused_sclk_sync, unused_sclk_fall, unused_lr_rise, unused_lr_fall;
    logic [1:0]       sd_pipe;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift_reg, left_hold;
    logic             prev_lr, word_done, word_done_q, word_ok, word_ch;

    i2s_rx_state_t    state, next_state;
    logic             good_seen, next_good_seen;
    logic             held, next_held;
    logic             capture_left, publish, error;

    sync_edge u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .sync (unused_sclk_sync),
        .rise (sclk_rise),
        .fall (unused_sclk_fall)
    );

    sync_edge u_lrclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (lrclk),
        .sync (lr_s),
        .rise (unused_lr_rise),
        .fall (unused_lr_fall)
    );

    // sd gets the same two-stage delay so it lines up with the detected sclk edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sd_pipe <= '0;
        else     sd_pipe <= {sd_pipe[0], sd};
    end
    assign sd_s = sd_pipe[1];

    // Bit capture. shift_reg stays untouched until the next sclk rise, which is at
    // least 4 clk away, so the FSM two clks later still sees the completed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is reset too, so a frame cut by reset never leaks stale bits.
            shift_reg   <= '0;
            bit_cnt     <= '0;
            prev_lr     <= 1'b0;
            word_done   <= 1'b0;
            word_done_q <= 1'b0;
            word_ok     <= 1'b0;
            word_ch     <= 1'b0;
        end else begin
            word_done   <= 1'b0;
            word_done_q <= word_done & enable;
            if (sclk_rise) begin
                shift_reg <= {shift_reg[WIDTH-2:0], sd_s};
                prev_lr   <= lr_s;
                if (lr_s != prev_lr) begin
                    word_done <= enable;
                    word_ok   <= (bit_cnt == CW'(WIDTH - 1));
                    word_ch   <= prev_lr;
                    bit_cnt   <= '0;
                end else if (bit_cnt != CW'(WIDTH + 1)) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state     = state;
        next_good_seen = good_seen;
        next_held      = held;
        capture_left   = 1'b0;
        publish        = 1'b0;
        error          = 1'b0;
        if (!enable) begin
            next_state     = HUNT;
            next_good_seen = 1'b0;
            next_held      = 1'b0;
        end else if (word_done_q) begin
            case (state)
                HUNT: begin
                    next_state     = SYNC;
                    next_good_seen = 1'b0;
                    next_held      = 1'b0;
                end
                SYNC, LOCKED: begin
                    if (!word_ok) begin
                        error          = 1'b1;
                        next_state     = SYNC;
                        next_good_seen = 1'b0;
                        next_held      = 1'b0;
                    end else begin
                        if (state == SYNC) begin
                            if (good_seen) begin
                                next_state     = LOCKED;
                                next_good_seen = 1'b0;
                            end else begin
                                next_good_seen = 1'b1;
                            end
                        end
                        if (!word_ch) begin
                            capture_left = 1'b1;
                            next_held    = 1'b1;
                        end else begin
                            publish   = held && (next_state == LOCKED);
                            next_held = 1'b0;
                        end
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            good_seen    <= 1'b0;
            held         <= 1'b0;
            left_hold    <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state        <= next_state;
            good_seen    <= next_good_seen;
            held         <= next_held;
            sample_valid <= publish;
            frame_err    <= error;
            if (capture_left) left_hold <= shift_reg;
            if (publish) begin
                left_data  <= left_hold;
                right_data <= shift_reg;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule
